ocs_beam_counter: RTL and testbench

//  Free-running PAL beam counter feeding ocs_video: generates line_start/line_pre_start strobes,

---
 rtl/ocs_pkg.sv | 26 ++
 rtl/ocs_beam_counter.sv | 114 +++++++++++
 tb/tb_ocs_beam_counter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ocs_pkg.sv
// PAL beam timing constants and VPOSR/VHPOSR packing helpers shared by the OCS video blocks.
package ocs_pkg;

  localparam int OCS_CLK_PER_LINE = 1920;
  localparam int OCS_COL_START    = 600;
  localparam int OCS_COL_MAX      = 452;
  localparam int OCS_LINES_SHORT  = 312;
  localparam int OCS_VBLANK_END   = 25;

  localparam int VPOSR_LOF_BIT = 15;
  localparam int VPOSR_V8_BIT  = 0;

  function automatic logic [15:0] make_vposr(input logic lof, input logic [8:0] vpos);
    logic [15:0] r;
    r = '0;
    r[VPOSR_LOF_BIT] = lof;
    r[VPOSR_V8_BIT]  = vpos[8];
    return r;
  endfunction

  // Horizontal position is reported in colour-clock units, i.e. the DMA column halved.
  function automatic logic [15:0] make_vhposr(input logic [8:0] vpos, input logic [8:0] hpos);
    return {vpos[7:0], hpos[8:1]};
  endfunction

endpackage

// File: rtl/ocs_beam_counter.sv
// Free-running PAL beam counter: line/frame strobes, DMA column, LOF and vertical blank.
// Optional light-pen position latch is enabled with `define OCS_BEAM_LIGHTPEN_EN.
module ocs_beam_counter
  import ocs_pkg::*;
#(
  parameter int CLK_PER_LINE = OCS_CLK_PER_LINE,
  parameter int COL_START    = OCS_COL_START,
  parameter int COL_MAX      = OCS_COL_MAX,
  parameter int LINES_SHORT  = OCS_LINES_SHORT,
  parameter int VBLANK_END   = OCS_VBLANK_END
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lace_i,
`ifdef OCS_BEAM_LIGHTPEN_EN
  input  logic        lpen_i,
  input  logic        lp_n,
  output logic        lp_latched,
`endif
  output logic        line_pre_start,
  output logic        line_start,
  output logic [8:0]  line_number,
  output logic [8:0]  column_number,
  output logic        long_frame,
  output logic        frame_start,
  output logic        vert_blank,
  output logic [15:0] vposr,
  output logic [15:0] vhposr
);

  localparam int HW = $clog2(CLK_PER_LINE);

  logic [HW-1:0] hcnt;
  logic          wrap;
  logic          last_line;
  logic [8:0]    line_next;
  logic [8:0]    vpos;
  logic [8:0]    hpos;

  assign wrap      = (hcnt == HW'(CLK_PER_LINE - 1));
  assign last_line = (line_number == 9'(long_frame ? LINES_SHORT : LINES_SHORT - 1));

  always_comb begin
    line_next = line_number;
    if (wrap)
      line_next = last_line ? 9'd0 : line_number + 9'd1;
  end

  // Strobes are decoded one count early so they line up with the hcnt they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt           <= '0;
      line_pre_start <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      line_number    <= '0;
      column_number  <= '0;
      long_frame     <= 1'b0;
      vert_blank     <= 1'b1;
    end else begin
      hcnt           <= wrap ? '0 : hcnt + 1'b1;
      line_pre_start <= (hcnt == HW'(CLK_PER_LINE - 2));
      line_start     <= wrap;
      frame_start    <= wrap && last_line;
      line_number    <= line_next;
      vert_blank     <= (line_next <= 9'(VBLANK_END));
      if (wrap) begin
        column_number <= '0;
        if (last_line)
          long_frame <= lace_i ? ~long_frame : 1'b1;
      end else if ((hcnt > HW'(COL_START)) && hcnt[0] && (column_number < 9'(COL_MAX))) begin
        column_number <= column_number + 9'd1;
      end
    end
  end

`ifdef OCS_BEAM_LIGHTPEN_EN
  logic       lp_s1, lp_s2, lp_s3;
  logic [8:0] lp_line, lp_col;

  // Two flops resynchronise lp_n; the third remembers the previous level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_s1      <= 1'b1;
      lp_s2      <= 1'b1;
      lp_s3      <= 1'b1;
      lp_latched <= 1'b0;
      lp_line    <= '0;
      lp_col     <= '0;
    end else begin
      lp_s1 <= lp_n;
      lp_s2 <= lp_s1;
      lp_s3 <= lp_s2;
      if (frame_start) begin
        lp_latched <= 1'b0;
      end else if (lpen_i && !lp_latched && lp_s3 && !lp_s2) begin
        lp_latched <= 1'b1;
        lp_line    <= line_number;
        lp_col     <= column_number;
      end
    end
  end

  assign vpos = lp_latched ? lp_line : line_number;
  assign hpos = lp_latched ? lp_col  : column_number;
`else
  assign vpos = line_number;
  assign hpos = column_number;
`endif

  assign vposr  = make_vposr(long_frame, vpos);
  assign vhposr = make_vhposr(vpos, hpos);

endmodule

// File: tb/tb_ocs_beam_counter.sv
// Directed bench for ocs_beam_counter on a shortened line (32 clk) with real PAL line counts.
module tb_ocs_beam_counter;

  localparam int CPL = 32;
  localparam int CS  = 8;
  localparam int CM  = 10;
  localparam int LS  = 312;
  localparam int VB  = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lace_i = 1'b0;
  logic        line_pre_start, line_start, long_frame, frame_start, vert_blank;
  logic [8:0]  line_number, column_number;
  logic [15:0] vposr, vhposr;
`ifdef OCS_BEAM_LIGHTPEN_EN
  logic        lpen_i = 1'b0;
  logic        lp_n = 1'b1;
  logic        lp_latched;
`endif

  int   checks = 0;
  int   failures = 0;
  int   hc, mline, cyc, nfs;
  logic mlof;
  int   fs_cyc [4];

  always #5 clk = ~clk;

  ocs_beam_counter #(
    .CLK_PER_LINE (CPL),
    .COL_START    (CS),
    .COL_MAX      (CM),
    .LINES_SHORT  (LS),
    .VBLANK_END   (VB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lace_i         (lace_i),
`ifdef OCS_BEAM_LIGHTPEN_EN
    .lpen_i         (lpen_i),
    .lp_n           (lp_n),
    .lp_latched     (lp_latched),
`endif
    .line_pre_start (line_pre_start),
    .line_start     (line_start),
    .line_number    (line_number),
    .column_number  (column_number),
    .long_frame     (long_frame),
    .frame_start    (frame_start),
    .vert_blank     (vert_blank),
    .vposr          (vposr),
    .vhposr         (vhposr)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  // Column increments on odd hcnt > CS, so value k first appears at hcnt CS+2k.
  function automatic int exp_col(input int h);
    int c;
    c = (h < CS + 2) ? 0 : (h - CS) / 2;
    return (c > CM) ? CM : c;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ls"},   16'(line_start),     16'd0);
    chk({tag, "_lps"},  16'(line_pre_start), 16'd0);
    chk({tag, "_fs"},   16'(frame_start),    16'd0);
    chk({tag, "_line"}, 16'(line_number),    16'd0);
    chk({tag, "_col"},  16'(column_number),  16'd0);
    chk({tag, "_lof"},  16'(long_frame),     16'd0);
    chk({tag, "_vb"},   16'(vert_blank),     16'd1);
    chk({tag, "_vposr"},  vposr,  16'h0000);
    chk({tag, "_vhposr"}, vhposr, 16'h0000);
  endtask

  task automatic chk_all();
    int col;
    col = exp_col(hc);
    chk("line_start",     16'(line_start),     16'(hc == 0 && cyc > 0));
    chk("line_pre_start", 16'(line_pre_start), 16'(hc == CPL - 1));
    chk("frame_start",    16'(frame_start),    16'(hc == 0 && mline == 0 && cyc > 0));
    chk("line_number",    16'(line_number),    16'(mline));
    chk("column_number",  16'(column_number),  16'(col));
    chk("long_frame",     16'(long_frame),     16'(mlof));
    chk("vert_blank",     16'(vert_blank),     16'(mline <= VB));
    chk("vposr",  vposr,  {mlof, 14'd0, 1'(mline >> 8)});
    chk("vhposr", vhposr, {8'(mline), 8'(col >> 1)});
  endtask

  task automatic step();
    @(posedge clk);
    if (hc == CPL - 1) begin
      hc = 0;
      if (mline == (mlof ? LS : LS - 1)) begin
        mline = 0;
        mlof  = lace_i ? ~mlof : 1'b1;
      end else begin
        mline++;
      end
    end else begin
      hc++;
    end
    cyc++;
    @(negedge clk);
    if (frame_start === 1'b1) begin
      if (nfs < 4) fs_cyc[nfs] = cyc;
      nfs++;
    end
    chk_all();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Reset is asserted off the clock edge to exercise the asynchronous path.
  task automatic do_reset(input logic lace);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("rst_async");
    lace_i = lace;
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("rst_hold");
    rst_n = 1'b1;
    hc = 0; mline = 0; mlof = 1'b0; cyc = 0; nfs = 0;
    for (int i = 0; i < 4; i++) fs_cyc[i] = -1;
    chk_all();
  endtask

  initial begin
    @(negedge clk);

    // Interlaced run: strobes, column ramp, vblank, then frame lengths 312/313/312.
    do_reset(1'b1);
    run_to(2 * CPL);
    run_to(25 * CPL + 5);
    chk("vb_line25", 16'(vert_blank), 16'd1);
    run_to(30 * CPL + 28);
    chk("vhposr_l30", vhposr, 16'h1E05);
    chk("vb_line30", 16'(vert_blank), 16'd0);
    run_to(9984 + 256 * CPL + 3);
    chk("vposr_l256_long", vposr, 16'h8001);
    run_to(30016);
    chk("lace_nfs", 16'(nfs), 16'd3);
    chk("lace_fs0", 16'(fs_cyc[0]), 16'(9984));
    chk("lace_fs1", 16'(fs_cyc[1]), 16'(20000));
    chk("lace_fs2", 16'(fs_cyc[2]), 16'(29984));
    chk("lace_lof3", 16'(long_frame), 16'd1);

    // Mid-line reset while column is non-zero, then non-interlaced run.
    run_to(30016 + 20);
    chk("pre_reset_col", 16'(column_number), 16'd6);
    do_reset(1'b0);
    run_to(5000);
    lace_i = 1'b1;
    run_to(6000);
    lace_i = 1'b0;
    run_to(15000);
    lace_i = 1'b1;
    run_to(16000);
    lace_i = 1'b0;
    run_to(18176 + 3);
    chk("vposr_l256_nolace", vposr, 16'h8001);
    run_to(20032);
    chk("nolace_nfs", 16'(nfs), 16'd2);
    chk("nolace_fs0", 16'(fs_cyc[0]), 16'(9984));
    chk("nolace_fs1", 16'(fs_cyc[1]), 16'(20000));
    chk("nolace_lof", 16'(long_frame), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
